wb_arbiter: RTL

- Shares the single general-register write port (wgenable/wgreg/wgdata) and the single float-register write port (wfenable/wfreg/wfdata) of the core between NREQ writeback requesters (ALU, load unit, FPU).
- Each cycle, for each register file independently, one requester is granted with a valid/ready handshake.
- The granted write is registered and driven to the core one cycle later.
- A saturating conflict counter exposes writeback contention for performance analysis.

---
 rtl/core_pkg.sv | 28 ++
 rtl/wb_pick.sv | 35 +++
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: register-file widths, writeback requester ids,
// the writeback request record and a one-hot to index helper.
package core_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_FPU = 2;

  typedef struct packed {
    logic              isf;
    logic [REG_W-1:0]  regidx;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Index of the set bit of a one-hot vector (up to 8 requesters).
  function automatic logic [2:0] onehot_idx8(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | ({3{oh[i]}} & 3'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_pick.sv
// Combinational one-hot picker. With WB_ARB_RR_EN defined the search starts
// at ptr_i and wraps; otherwise the lowest-index request wins.
module wb_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
`ifdef WB_ARB_RR_EN
  input  logic [PTR_W-1:0] ptr_i,
`endif
  input  logic [NREQ-1:0]  req_i,
  output logic [NREQ-1:0]  gnt_o
);

  // First requester found in search order takes the grant.
  always_comb begin
    logic found;
    int   idx;
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef WB_ARB_RR_EN
      idx = (int'(ptr_i) + k) % NREQ;
`else
      idx = k;
`endif
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the general and float register write ports among
// NREQ requesters. Define WB_ARB_RR_EN for round-robin, else fixed priority.
module wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_isf,
  input  logic [NREQ*REG_W-1:0]  req_reg,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wgenable,
  output logic [REG_W-1:0]       wgreg,
  output logic [DATA_W-1:0]      wgdata,
  output logic                   wfenable,
  output logic [REG_W-1:0]       wfreg,
  output logic [DATA_W-1:0]      wfdata,
  output logic [CNT_W-1:0]       conflict_cnt
);

  import core_pkg::*;

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   g_req_s, f_req_s, g_gnt_s, f_gnt_s;
  logic [REG_W-1:0]  g_reg_s, f_reg_s;
  logic [DATA_W-1:0] g_data_s, f_data_s;
  logic              conflict_s;

  logic              wgen_q, wgen_d, wfen_q, wfen_d;
  logic [REG_W-1:0]  wgreg_q, wgreg_d, wfreg_q, wfreg_d;
  logic [DATA_W-1:0] wgdata_q, wgdata_d, wfdata_q, wfdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign g_req_s = req_valid & ~req_isf;
  assign f_req_s = req_valid &  req_isf;

`ifdef WB_ARB_RR_EN
  logic [PTR_W-1:0] ptr_g_q, ptr_g_d, ptr_f_q, ptr_f_d;

  wb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_g (
    .ptr_i(ptr_g_q), .req_i(g_req_s), .gnt_o(g_gnt_s)
  );
  wb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_f (
    .ptr_i(ptr_f_q), .req_i(f_req_s), .gnt_o(f_gnt_s)
  );

  // Pointer moves just past the winner; unchanged without a grant.
  always_comb begin
    if (|g_gnt_s) begin
      ptr_g_d = PTR_W'((int'(onehot_idx8(8'(g_gnt_s))) + 1) % NREQ);
    end else begin
      ptr_g_d = ptr_g_q;
    end
    if (|f_gnt_s) begin
      ptr_f_d = PTR_W'((int'(onehot_idx8(8'(f_gnt_s))) + 1) % NREQ);
    end else begin
      ptr_f_d = ptr_f_q;
    end
  end

  // Round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_g_q <= '0;
      ptr_f_q <= '0;
    end else begin
      ptr_g_q <= ptr_g_d;
      ptr_f_q <= ptr_f_d;
    end
  end
`else
  wb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_g (
    .req_i(g_req_s), .gnt_o(g_gnt_s)
  );
  wb_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_f (
    .req_i(f_req_s), .gnt_o(f_gnt_s)
  );
`endif

  assign req_ready = rstn ? (g_gnt_s | f_gnt_s) : '0;

  // AND-OR payload mux driven by the one-hot grants.
  always_comb begin
    g_reg_s  = '0;
    f_reg_s  = '0;
    g_data_s = '0;
    f_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      g_reg_s  = g_reg_s  | ({REG_W{g_gnt_s[i]}}  & req_reg[i*REG_W +: REG_W]);
      f_reg_s  = f_reg_s  | ({REG_W{f_gnt_s[i]}}  & req_reg[i*REG_W +: REG_W]);
      g_data_s = g_data_s | ({DATA_W{g_gnt_s[i]}} & req_data[i*DATA_W +: DATA_W]);
      f_data_s = f_data_s | ({DATA_W{f_gnt_s[i]}} & req_data[i*DATA_W +: DATA_W]);
    end
  end

  assign conflict_s = |(req_valid & ~(g_gnt_s | f_gnt_s));

  // Next-state for write ports; r0 of the general file is never enabled.
  always_comb begin
    wgen_d = (|g_gnt_s) && (g_reg_s != '0);
    wfen_d = |f_gnt_s;
    if (|g_gnt_s) begin
      wgreg_d  = g_reg_s;
      wgdata_d = g_data_s;
    end else begin
      wgreg_d  = wgreg_q;
      wgdata_d = wgdata_q;
    end
    if (|f_gnt_s) begin
      wfreg_d  = f_reg_s;
      wfdata_d = f_data_s;
    end else begin
      wfreg_d  = wfreg_q;
      wfdata_d = wfdata_q;
    end
    if (conflict_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wgen_q   <= 1'b0;
      wfen_q   <= 1'b0;
      wgreg_q  <= '0;
      wfreg_q  <= '0;
      wgdata_q <= '0;
      wfdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      wgen_q   <= wgen_d;
      wfen_q   <= wfen_d;
      wgreg_q  <= wgreg_d;
      wfreg_q  <= wfreg_d;
      wgdata_q <= wgdata_d;
      wfdata_q <= wfdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wgenable     = wgen_q;
  assign wgreg        = wgreg_q;
  assign wgdata       = wgdata_q;
  assign wfenable     = wfen_q;
  assign wfreg        = wfreg_q;
  assign wfdata       = wfdata_q;
  assign conflict_cnt = cnt_q;

endmodule
